// File: rtl/sigmoid_pkg.sv
// rtl/sigmoid_pkg.sv - shared widths, limits and FSM state type for the sigmoid scheduler
package sigmoid_pkg;

   localparam int Z_W             = 8;
   localparam int H_W             = 8;
   localparam int MAX_LUT_LATENCY = 7;
   localparam int CNT_W           = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last grant
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_last_grant,
   output logic [N_REQ-1:0] o_grant,
   output logic [IDX_W-1:0] o_grant_idx
);

   // walk from the farthest to the nearest candidate so the nearest requester overwrites
   always_comb begin
      int j;
      o_grant     = '0;
      o_grant_idx = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         j = (int'(i_last_grant) + k) % N_REQ;
         if (i_req[j[IDX_W-1:0]]) begin
            o_grant                 = '0;
            o_grant[j[IDX_W-1:0]]   = 1'b1;
            o_grant_idx             = j[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/sigmoid_scheduler.sv
// rtl/sigmoid_scheduler.sv - shares one sigmoid LUT among N_REQ requesters, one operation at a time
module sigmoid_scheduler
   import sigmoid_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int LUT_LATENCY = 1,
   localparam int IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*Z_W-1:0]   req_z,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   lut_en,
   output logic [Z_W-1:0]         lut_z,
   input  logic [H_W-1:0]         lut_h,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [H_W-1:0]         resp_h,
   output logic [IDX_W-1:0]       resp_id,
   output logic                   busy
);

   state_t             r_state;
   state_t             w_next;
   logic [IDX_W-1:0]   r_last;
   logic [CNT_W-1:0]   r_cnt;
   logic [Z_W-1:0]     r_z;
   logic [IDX_W-1:0]   r_id;
   logic [H_W-1:0]     r_resp_h;
   logic [N_REQ-1:0]   w_grant;
   logic [IDX_W-1:0]   w_grant_idx;
   logic [Z_W-1:0]     w_sel_z;
   logic               w_accept;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .i_req        (req_valid),
      .i_last_grant (r_last),
      .o_grant      (w_grant),
      .o_grant_idx  (w_grant_idx)
   );

   assign w_accept = (r_state == ST_IDLE) && (|req_valid);

   // pick the winner's operand out of the packed request bus
   always_comb begin
      w_sel_z = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_grant[i]) w_sel_z = req_z[i*Z_W +: Z_W];
      end
   end

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // next-state: accept, issue once, wait out the LUT latency, hold the response until taken
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (|req_valid)              w_next = ST_ISSUE;
         ST_ISSUE:                              w_next = ST_WAIT;
         ST_WAIT:  if (r_cnt <= CNT_W'(1))      w_next = ST_RESP;
         ST_RESP:  if (resp_ready)              w_next = ST_IDLE;
         default:                               w_next = ST_IDLE;
      endcase
   end

   // outputs decoded from state; ready is suppressed while reset is held
   always_comb begin
      req_ready  = '0;
      lut_en     = 1'b0;
      resp_valid = 1'b0;
      busy       = (r_state != ST_IDLE);
      case (r_state)
         ST_IDLE:  if (reset) req_ready = w_grant;
         ST_ISSUE: lut_en     = 1'b1;
         ST_WAIT:  lut_en     = 1'b1;
         ST_RESP:  resp_valid = 1'b1;
         default:  ;
      endcase
   end

   // datapath: latch the winner, run the latency counter, capture the LUT result
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last   <= IDX_W'(N_REQ - 1);
         r_cnt    <= '0;
         r_z      <= '0;
         r_id     <= '0;
         r_resp_h <= '0;
      end else begin
         if (w_accept) begin
            r_z    <= w_sel_z;
            r_id   <= w_grant_idx;
            r_last <= w_grant_idx;
         end
         if (r_state == ST_ISSUE) begin
            r_cnt <= CNT_W'(LUT_LATENCY);
         end
         if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt <= CNT_W'(1)) r_resp_h <= lut_h;
         end
      end
   end

   // operand stays on the LUT bus between operations
   assign lut_z   = r_z;
   assign resp_h  = r_resp_h;
   assign resp_id = r_id;

endmodule

// File: tb/tb_sigmoid_scheduler.sv
// tb/tb_sigmoid_scheduler.sv - randomized self-checking bench for sigmoid_scheduler
module tb_sigmoid_scheduler;

   localparam int N = 4;
   localparam int L = 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [N-1:0]  req_valid = '0;
   logic [N*8-1:0] req_z = '0;
   logic [N-1:0]  req_ready;
   logic          lut_en;
   logic [7:0]    lut_z;
   logic [7:0]    lut_h = 8'h00;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [7:0]    resp_h;
   logic [1:0]    resp_id;
   logic          busy;

   logic [7:0]    tab [256];
   int            n_chk = 0;
   int            n_err = 0;
   int            m_last = N - 1;

   sigmoid_scheduler #(.N_REQ(N), .LUT_LATENCY(L)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_z      (req_z),
      .req_ready  (req_ready),
      .lut_en     (lut_en),
      .lut_z      (lut_z),
      .lut_h      (lut_h),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_h     (resp_h),
      .resp_id    (resp_id),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // shared LUT model, one cycle from enable to result
   always @(posedge clk) if (lut_en) lut_h <= tab[lut_z];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int rr_model(input int last, input logic [N-1:0] v);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, req_ready, 0);
      chk({tag, "_lut_en"}, lut_en, 0);
      chk({tag, "_lut_z"}, lut_z, 0);
      chk({tag, "_resp_valid"}, resp_valid, 0);
      chk({tag, "_resp_h"}, resp_h, 0);
      chk({tag, "_resp_id"}, resp_id, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   // one full transaction: accept, in-flight, response held for `hold` cycles
   task automatic run_txn(input logic [N-1:0] v, input logic [31:0] zf, input int hold, input bit jitter);
      int         w;
      logic [7:0] ez;
      logic [7:0] eh;
      @(negedge clk);
      req_valid  = v;
      req_z      = zf;
      resp_ready = 1'b0;
      #1;
      w = rr_model(m_last, v);
      chk("accept_ready", req_ready, (w < 0) ? 32'd0 : (32'd1 << w));
      if (w < 0) return;
      m_last = w;
      ez = zf[8*w +: 8];
      eh = tab[ez];
      for (int k = 1; k <= L + 1; k++) begin
         @(negedge clk);
         if (jitter) begin
            req_valid = N'($urandom);
            req_z     = $urandom;
         end
         #1;
         chk("flight_ready", req_ready, 0);
         chk("flight_lut_en", lut_en, 1);
         chk("flight_lut_z", lut_z, ez);
         chk("flight_resp_valid", resp_valid, 0);
         chk("flight_busy", busy, 1);
      end
      for (int c = 0; c <= hold; c++) begin
         @(negedge clk);
         if (jitter) begin
            req_valid = N'($urandom);
            req_z     = $urandom;
         end
         resp_ready = (c == hold);
         #1;
         chk("resp_valid", resp_valid, 1);
         chk("resp_h", resp_h, eh);
         chk("resp_id", resp_id, w);
         chk("resp_req_ready", req_ready, 0);
         chk("resp_lut_en", lut_en, 0);
         chk("resp_lut_z_hold", lut_z, ez);
      end
   endtask

   initial begin
      int w;
      for (int i = 0; i < 256; i++) tab[i] = 8'((i * 37 + 11) & 8'hFF);
      tab[8'h01] = 8'h80;
      tab[8'h40] = 8'hBB;
      tab[8'h10] = 8'h8F;
      tab[8'h80] = 8'hE1;
      tab[8'hFF] = 8'hFB;

      // reset with requests pending: nothing may be granted
      req_valid = 4'hF;
      req_z     = 32'hFF801040;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk_reset_vals("rst");

      @(negedge clk);
      reset     = 1'b1;
      req_valid = '0;
      #1;
      chk("idle_ready", req_ready, 0);
      chk("idle_busy", busy, 0);

      // single request, z=0x01
      run_txn(4'b0001, 32'h00000001, 0, 1'b0);

      // all four at once, then the next round restarts at id 0
      for (int r = 0; r < 5; r++) run_txn(4'hF, 32'hFF801040, 0, 1'b0);

      // backpressure for five cycles
      run_txn(4'b0110, 32'h00004000, 5, 1'b0);

      // fairness between requesters 1 and 3
      for (int r = 0; r < 6; r++) run_txn(4'b1010, $urandom, 1, 1'b0);

      // reset during WAIT aborts the operation
      @(negedge clk);
      req_valid  = 4'b0100;
      req_z      = $urandom;
      resp_ready = 1'b1;
      #1;
      w = rr_model(m_last, 4'b0100);
      chk("abort_accept", req_ready, 32'd1 << w);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("abort_in_wait", lut_en, 1);
      reset = 1'b0;
      #1;
      chk_reset_vals("abort");
      m_last = N - 1;
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("abort_no_resp", resp_valid, 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("after_abort_busy", busy, 0);
      chk("after_abort_resp", resp_valid, 0);
      run_txn(4'b0110, 32'h00C3A500, 0, 1'b0);

      // randomized traffic with mid-flight request churn and random backpressure
      for (int r = 0; r < 40; r++) begin
         run_txn(N'($urandom_range(1, 15)), $urandom, $urandom_range(0, 3), 1'b1);
      end

      @(negedge clk);
      req_valid  = '0;
      resp_ready = 1'b0;
      #1;
      chk("final_busy", busy, 0);
      chk("final_resp_valid", resp_valid, 0);
      chk("final_lut_en", lut_en, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/sigmoid_scheduler.md
SIGMOID_SCHEDULER -- requirements
Module: sigmoid_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one sigmoid LUT.
REQ-002 SHALL have parameter LUT_LATENCY, default 1, clock cycles from lut_en/lut_z to a valid lut_h (range 1..7).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (asserted when 0).
REQ-005 SHALL have port req_valid, input, N_REQ, per-requester request strobe.
REQ-006 SHALL have port req_z, input, N_REQ*8, per-requester 8-bit z operand (requester i at bits [8i+7:8i]).
REQ-007 SHALL have port req_ready, output, N_REQ, one-hot accept; a request transfers when req_valid[i] and req_ready[i] are both 1.
REQ-008 SHALL have port lut_en, output, 1, enable driven to the shared LUT.
REQ-009 SHALL have port lut_z, output, 8, operand driven to the shared LUT.
REQ-010 SHALL have port lut_h, input, 8, LUT result.
REQ-011 SHALL have port resp_valid, output, 1, result available.
REQ-012 SHALL have port resp_ready, input, 1, consumer accepts result.
REQ-013 SHALL have port resp_h, output, 8, sigmoid result.
REQ-014 SHALL have port resp_id, output, $clog2(N_REQ), index of requester owning resp_h.
REQ-015 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; one LUT operation in flight at a time.
REQ-017 IDLE: if any req_valid bit is 1, SHALL assert exactly one req_ready bit (combinationally, same cycle) for the round-robin winner, latch its z and id, and go to ISSUE; otherwise stay in IDLE with req_ready all 0.
REQ-018 Round-robin: search SHALL start at last_grant+1 modulo N_REQ; last_grant SHALL update to the winner on each accept.
REQ-019 ISSUE (1 cycle): lut_en SHALL be 1 and lut_z SHALL be the latched z; wait counter loads LUT_LATENCY; go to WAIT.
REQ-020 WAIT: lut_en SHALL remain 1 with lut_z held; counter decrements each cycle; on the cycle counter equals 1, lut_h SHALL be captured into resp_h and state SHALL go to RESP.
REQ-021 Latency: with accept in cycle T, resp_valid SHALL first be 1 in cycle T+2+LUT_LATENCY.
REQ-022 RESP: resp_valid SHALL be 1 with resp_h/resp_id stable until resp_ready is 1; on that cycle state SHALL return to IDLE.
REQ-023 A new request SHALL NOT be accepted in the same cycle a response completes; earliest next accept is the following IDLE cycle.
REQ-024 req_ready SHALL be all 0 in ISSUE, WAIT and RESP; requesters holding req_valid keep their request pending.
REQ-025 Outside ISSUE/WAIT, lut_en SHALL be 0 and lut_z SHALL hold its last value.
REQ-026 A requester deasserting req_valid while not granted SHALL be dropped without side effects.
REQ-027 lut_h SHALL be passed through unmodified; z=0 (LUT output 0) SHALL not be special-cased.

Reset
REQ-028 While reset is 0: state IDLE, last_grant N_REQ-1 (requester 0 wins first), counter 0, req_ready 0, lut_en 0, lut_z 0, resp_valid 0, resp_h 0, resp_id 0, busy 0.
REQ-029 Reset asserted mid-operation SHALL abort the in-flight operation immediately; no response is produced for it.

Structure
REQ-030 Shared package sigmoid_pkg SHALL hold Z_W=8, H_W=8, the FSM state enum, and the max LUT_LATENCY constant.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs request vector, last_grant; outputs one-hot grant and grant index).

Verification (bench uses a LUT model with LUT_LATENCY=1)
REQ-032 Single request: req 0 with z=0x01 accepted at T -> resp_valid at T+3, resp_h=0x80, resp_id=0.
REQ-033 All four requesting simultaneously, resp_ready held 1: z=0x40,0x10,0x80,0xFF -> responses in id order 0,1,2,3 with resp_h 0xBB,0x8F,0xE1,0xFB; next round starts at id 0.
REQ-034 Backpressure: resp_ready held 0 for 5 cycles -> resp_valid, resp_h, resp_id stable; req_ready stays 0 until one cycle after resp_ready=1.
REQ-035 Fairness: requesters 1 and 3 continuously valid -> grants alternate 1,3,1,3 with no starvation.
REQ-036 Reset pulse during WAIT -> all outputs return to REQ-028 values asynchronously; no resp_valid for the aborted request; next request served normally.
